// File: rtl/spi_request_arbiter.sv
// spi_request_arbiter: round-robin sharing of one SPI master among four
// requesters. A winner's slave select and register address are registered
// onto the master for a fixed window, then the master's byte is captured and
// returned with a one-cycle ACK.
module spi_request_arbiter #(
  parameter int unsigned XFER_CYCLES = 50
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  REQ,
  input  logic [7:0]  REQ_SS_ADDR,
  input  logic [31:0] REQ_DATA_ADDR,
  input  logic [7:0]  M_DATA,
  output logic [1:0]  SS_ADDR,
  output logic [7:0]  DATA_ADDR,
  output logic [3:0]  GNT,
  output logic [3:0]  ACK,
  output logic [7:0]  RDATA,
  output logic        BUSY
);

  localparam int unsigned CNT_W = (XFER_CYCLES > 32'd1) ? $clog2(XFER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XFER_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Round-robin search starting at pri; result is {found, index}.
  // The loop runs from the farthest offset down so the nearest hit wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] pri);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = pri + 2'(k);
      res = req[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       pri_q, pri_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ss_q, ss_d;
  logic [7:0]       da_q, da_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [3:0]       ack_q, ack_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             busy_q, busy_d;
  logic [2:0]       pick_s;
  logic [1:0]       win_s;

  assign pick_s = rr_pick(REQ, pri_q);
  assign win_s  = pick_s[1:0];

  // State and output registers; reset aborts any transfer without an ACK.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      pri_q   <= 2'd0;
      cnt_q   <= '0;
      ss_q    <= 2'd0;
      da_q    <= 8'd0;
      gnt_q   <= 4'd0;
      ack_q   <= 4'd0;
      rdata_q <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      cnt_q   <= cnt_d;
      ss_q    <= ss_d;
      da_q    <= da_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: grant in IDLE, count down the window, capture and ACK.
  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    cnt_d   = cnt_q;
    ss_d    = ss_q;
    da_d    = da_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_s[2]) begin
          state_d = ST_XFER;
          gnt_d   = 4'b0001 << win_s;
          ss_d    = REQ_SS_ADDR[{win_s, 1'b0} +: 2];
          da_d    = REQ_DATA_ADDR[{win_s, 3'b000} +: 8];
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          pri_d   = win_s + 2'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        // Request inputs are deliberately not looked at here: the window
        // always runs to completion once granted.
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          rdata_d = M_DATA;
          ack_d   = gnt_q;
          gnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ack_d   = 4'd0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'd0;
        ack_d   = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign SS_ADDR   = ss_q;
  assign DATA_ADDR = da_q;
  assign GNT       = gnt_q;
  assign ACK       = ack_q;
  assign RDATA     = rdata_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// tb_spi_request_arbiter: scoreboard bench. Expected transactions are queued
// as requests are driven; a negedge monitor checks grant and ACK against them.
module tb_spi_request_arbiter;

  localparam int XC = 50;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  REQ;
  logic [7:0]  REQ_SS_ADDR;
  logic [31:0] REQ_DATA_ADDR;
  logic [7:0]  M_DATA;
  logic [1:0]  SS_ADDR;
  logic [7:0]  DATA_ADDR;
  logic [3:0]  GNT;
  logic [3:0]  ACK;
  logic [7:0]  RDATA;
  logic        BUSY;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         port;
    logic [1:0] ss;
    logic [7:0] da;
    logic [7:0] rdata;
    int         gap;
  } exp_t;

  exp_t sb[$];

  spi_request_arbiter #(.XFER_CYCLES(XC)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_SS_ADDR(REQ_SS_ADDR),
    .REQ_DATA_ADDR(REQ_DATA_ADDR), .M_DATA(M_DATA), .SS_ADDR(SS_ADDR),
    .DATA_ADDR(DATA_ADDR), .GNT(GNT), .ACK(ACK), .RDATA(RDATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Slave register contents as seen through the master.
  function automatic logic [7:0] slave_byte(input logic [1:0] ss, input logic [7:0] da);
    case ({ss, da})
      10'h01A: return 8'h41;
      10'h01B: return 8'hDC;
      10'h11C: return 8'h3B;
      10'h21D: return 8'h4E;
      10'h32A: return 8'h8C;
      default: return da ^ {ss, 6'h15};
    endcase
  endfunction

  assign M_DATA = slave_byte(SS_ADDR, DATA_ADDR);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int p, input logic [1:0] ss, input logic [7:0] da);
    REQ_SS_ADDR[2*p +: 2]   = ss;
    REQ_DATA_ADDR[8*p +: 8] = da;
    REQ[p]                  = 1'b1;
  endtask

  task automatic push_exp(input int p, input logic [1:0] ss, input logic [7:0] da, input int gap);
    exp_t e;
    e.port  = p;
    e.ss    = ss;
    e.da    = da;
    e.rdata = slave_byte(ss, da);
    e.gap   = gap;
    sb.push_back(e);
  endtask

  task automatic wait_gnt();
    bit found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (GNT != 4'd0) found = 1'b1;
    end
    if (!found) check_eq("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_ack(output logic [3:0] a);
    bit found = 1'b0;
    a = 4'd0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (ACK != 4'd0) begin
        found = 1'b1;
        a     = ACK;
      end
    end
    if (!found) check_eq("ack_timeout", 32'd0, 32'd1);
  endtask

  // Cycle counter used for latency and spacing checks.
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Monitor: compares grants and ACKs against the scoreboard head.
  initial begin
    logic [3:0] gnt_prev;
    int         gnt_cyc;
    int         last_gnt;
    bit         ack_follow;
    gnt_prev   = 4'd0;
    gnt_cyc    = 0;
    last_gnt   = 0;
    ack_follow = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        gnt_prev   = 4'd0;
        ack_follow = 1'b0;
      end else begin
        if (ack_follow) begin
          check_eq("ack_one_cycle", ACK, 32'd0);
          check_eq("busy_after_done", BUSY, 32'd0);
          ack_follow = 1'b0;
        end
        if (GNT != 4'd0 && gnt_prev == 4'd0) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_gnt", GNT, 32'd0);
          end else begin
            check_eq("gnt_onehot", GNT, 32'd1 << sb[0].port);
            check_eq("gnt_ss_addr", SS_ADDR, sb[0].ss);
            check_eq("gnt_data_addr", DATA_ADDR, sb[0].da);
            check_eq("gnt_busy", BUSY, 32'd1);
            if (sb[0].gap != 0) check_eq("gnt_spacing", cyc - last_gnt, sb[0].gap);
            gnt_cyc  = cyc;
            last_gnt = cyc;
          end
        end
        if (ACK != 4'd0) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_ack", ACK, 32'd0);
          end else begin
            check_eq("ack_onehot", ACK, 32'd1 << sb[0].port);
            check_eq("ack_rdata", RDATA, sb[0].rdata);
            check_eq("ack_latency", cyc - gnt_cyc, XC);
            check_eq("ack_ss_held", SS_ADDR, sb[0].ss);
            check_eq("ack_da_held", DATA_ADDR, sb[0].da);
            check_eq("ack_gnt_clear", GNT, 32'd0);
            void'(sb.pop_front());
            ack_follow = 1'b1;
          end
        end
        gnt_prev = GNT;
      end
    end
  end

  // Directed sequences; expectations queued alongside the stimulus.
  initial begin
    logic [3:0] a;
    RST_N         = 1'b0;
    REQ           = 4'd0;
    REQ_SS_ADDR   = 8'd0;
    REQ_DATA_ADDR = 32'd0;
    #1;
    check_eq("rst_ss_addr", SS_ADDR, 32'd0);
    check_eq("rst_data_addr", DATA_ADDR, 32'd0);
    check_eq("rst_gnt", GNT, 32'd0);
    check_eq("rst_ack", ACK, 32'd0);
    check_eq("rst_rdata", RDATA, 32'd0);
    check_eq("rst_busy", BUSY, 32'd0);
    tick();
    tick();
    RST_N = 1'b1;
    tick();

    // All four at once: served 0,1,2,3 at 52-cycle spacing.
    set_req(0, 2'd0, 8'h1B);
    set_req(1, 2'd1, 8'h1C);
    set_req(2, 2'd2, 8'h1D);
    set_req(3, 2'd3, 8'h2A);
    push_exp(0, 2'd0, 8'h1B, 0);
    push_exp(1, 2'd1, 8'h1C, XC + 2);
    push_exp(2, 2'd2, 8'h1D, XC + 2);
    push_exp(3, 2'd3, 8'h2A, XC + 2);
    for (int k = 0; k < 4; k++) begin
      wait_ack(a);
      REQ = REQ & ~a;
    end
    tick();
    tick();

    // Single request: one-edge grant latency, byte 41.
    set_req(0, 2'd0, 8'h1A);
    push_exp(0, 2'd0, 8'h1A, 0);
    tick();
    check_eq("t1_gnt", GNT, 32'h1);
    check_eq("t1_ss", SS_ADDR, 32'h0);
    check_eq("t1_da", DATA_ADDR, 32'h1A);
    check_eq("t1_busy", BUSY, 32'd1);
    wait_ack(a);
    REQ = 4'd0;
    tick();
    tick();
    check_eq("t1_rdata_hold", RDATA, 32'h41);
    check_eq("t1_busy_low", BUSY, 32'd0);
    check_eq("t1_da_hold", DATA_ADDR, 32'h1A);

    // Request dropped and address changed mid-window.
    set_req(2, 2'd2, 8'h1D);
    push_exp(2, 2'd2, 8'h1D, 0);
    wait_gnt();
    repeat (20) tick();
    REQ[2]               = 1'b0;
    REQ_SS_ADDR[5:4]     = 2'd3;
    REQ_DATA_ADDR[23:16] = 8'h2A;
    repeat (5) tick();
    check_eq("t4_ss_stable", SS_ADDR, 32'd2);
    check_eq("t4_da_stable", DATA_ADDR, 32'h1D);
    check_eq("t4_gnt_held", GNT, 32'h4);
    wait_ack(a);
    tick();
    tick();

    // Fairness: 0 and 2 hold requests; 1 joins while PRI points at it.
    set_req(0, 2'd0, 8'h1B);
    set_req(2, 2'd2, 8'h1D);
    push_exp(0, 2'd0, 8'h1B, 0);
    push_exp(2, 2'd2, 8'h1D, XC + 2);
    push_exp(0, 2'd0, 8'h1B, XC + 2);
    push_exp(1, 2'd1, 8'h1C, XC + 2);
    push_exp(2, 2'd2, 8'h1D, XC + 2);
    for (int k = 0; k < 5; k++) begin
      wait_ack(a);
      if (a == 4'b0010) REQ[1] = 1'b0;
      if (k == 4) REQ = 4'd0;
      if (k == 1) begin
        repeat (5) tick();
        set_req(1, 2'd1, 8'h1C);
      end
    end
    tick();
    tick();

    // Reset in the middle of a window: immediate clear, no ACK, PRI back to 0.
    set_req(1, 2'd1, 8'h1C);
    push_exp(1, 2'd1, 8'h1C, 0);
    wait_gnt();
    repeat (20) tick();
    RST_N = 1'b0;
    sb.delete();
    #1;
    check_eq("mid_rst_gnt", GNT, 32'd0);
    check_eq("mid_rst_ack", ACK, 32'd0);
    check_eq("mid_rst_busy", BUSY, 32'd0);
    check_eq("mid_rst_ss", SS_ADDR, 32'd0);
    check_eq("mid_rst_da", DATA_ADDR, 32'd0);
    check_eq("mid_rst_rdata", RDATA, 32'd0);
    set_req(0, 2'd0, 8'h1A);
    push_exp(0, 2'd0, 8'h1A, 0);
    push_exp(1, 2'd1, 8'h1C, XC + 2);
    repeat (3) tick();
    RST_N = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_ack(a);
      REQ = REQ & ~a;
    end
    repeat (4) tick();
    check_eq("sb_empty", sb.size(), 32'd0);
    check_eq("final_gnt_idle", GNT, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_request_arbiter.md
# spi_request_arbiter

Round-robin arbiter that shares the single `master_device` SPI master among four requesters. Each requester presents a target slave select (SS_ADDR) and a register address (DATA_ADDR). The arbiter grants one requester at a time and drives the master's SS_ADDR/DATA_ADDR inputs. It holds them stable for a fixed transfer window, then captures the master's DATA and returns it to the granted requester with a one-cycle ACK. It sits between the requesting logic and `master_device`; the four `slave_device` instances are unchanged.

## Interface
- XFER_CYCLES, 50, CLK cycles each transaction is held on the master (50 = 500 ns at a 10 ns CLK); legal range 2..1023
- CLK  in  1  system clock, rising-edge
- RST_N  in  1  asynchronous, active-low reset
- REQ  in  4  per-requester request level; bit i = requester i
- REQ_SS_ADDR  in  8  packed slave selects; bits [2i+1:2i] = requester i
- REQ_DATA_ADDR  in  32  packed register addresses; bits [8i+7:8i] = requester i
- M_DATA  in  8  retrieved byte from `master_device` DATA
- SS_ADDR  out  2  to `master_device` SS_ADDR
- DATA_ADDR  out  8  to `master_device` DATA_ADDR
- GNT  out  4  one-hot grant, high for the whole transfer window
- ACK  out  4  one-hot, one-cycle pulse; RDATA valid while high
- RDATA  out  8  captured M_DATA
- BUSY  out  1  high in XFER and DONE

## Operation
- Reset (RST_N low, asynchronous, any state): state=IDLE, SS_ADDR=0, DATA_ADDR=0, GNT=0, ACK=0, RDATA=0, BUSY=0, round-robin pointer PRI=0, counter=0. Reset takes effect immediately mid-transfer. No ACK is issued for an aborted transfer.
- States:
  - IDLE: if REQ≠0, arbitrate and go to XFER. Otherwise stay.
  - XFER: counter decrements. At counter==0, go to DONE.
  - DONE: one cycle, then go to IDLE.
- Arbitration: search REQ starting at index PRI, ascending modulo 4. The first set bit, W, wins. On grant, PRI←(W+1) mod 4.
- On grant edge:
  - GNT←one-hot(W).
  - SS_ADDR←REQ_SS_ADDR[W].
  - DATA_ADDR←REQ_DATA_ADDR[W].
  - counter←XFER_CYCLES−1.
  - BUSY←1.
- SS_ADDR and DATA_ADDR are registered and stable for the full window. They hold their last values in IDLE and are not returned to 0.
- Request-input changes during XFER are ignored, including REQ[W] dropping or address changes. The transfer completes and ACK is still issued.
- On XFER→DONE edge: RDATA←M_DATA, ACK←GNT, GNT←0.
- On DONE→IDLE edge: ACK←0, BUSY←0. RDATA holds until the next capture.
- Requester contract: drop REQ within one cycle after its ACK. A REQ still high is treated as a new request, and it loses to other pending requesters via PRI.
- Counter width: ceil(log2(XFER_CYCLES)). No wrap; it is reloaded only on grant.

## Timing
- Grant latency: REQ high at IDLE sampling edge E0 gives GNT, SS_ADDR and DATA_ADDR valid after E0.
- Capture edge: E0+XFER_CYCLES.
- ACK high for the cycle between E0+XFER_CYCLES and E0+XFER_CYCLES+1.
- Next grant earliest at edge E0+XFER_CYCLES+2. Transaction period is XFER_CYCLES+2 cycles.
- Simultaneous requests in IDLE: exactly one grant, chosen by PRI. The others stay pending with no loss.
- Worst-case wait for a continuously requesting port: 3 full transactions.

## Test plan
- Single request, XFER_CYCLES=50:
  - Stimulus: REQ=0001, SS_ADDR 0, DATA_ADDR 8'h1A.
  - Response: GNT=0001 and SS_ADDR=0/DATA_ADDR=1A one edge later. ACK=0001 with RDATA=8'h41 exactly 50 edges after grant, for one cycle. BUSY low 2 cycles later.
- All four request together, with addresses 1B/1C/1D/2A to slaves 0..3:
  - Grants occur in order 0,1,2,3, 52 cycles apart.
  - RDATA=DC,3B,4E,8C respectively.
- Fairness: requesters 0 and 2 hold REQ high permanently.
  - Grants alternate 0,2,0,2.
  - Requester 1, raised later, is served before 2's next turn when PRI=1.
- REQ[W] dropped and DATA_ADDR changed mid-XFER:
  - SS_ADDR/DATA_ADDR stay unchanged on the master.
  - ACK still issued with the originally addressed byte.
- RST_N low at cycle 20 of XFER:
  - All outputs reset immediately and no ACK is issued.
  - After release, REQ=0010 is granted first only if no lower-index request is pending (PRI=0).
- Reset values checked before any clock: SS_ADDR=0, DATA_ADDR=00, GNT=0, ACK=0, RDATA=00, BUSY=0.
